// File: rtl/uart_sample_host_if.sv
// Bundles the command, serial and sample signals of uart_sample_host.
// The slave modport is the host-block side; master is the driver side.
interface uart_sample_host_if;
    logic        start_i;
    logic        busy_o;
    logic        tx_o;
    logic        rx_i;
    logic [11:0] sample_o;
    logic        sample_valid_o;
    logic        err_o;

    modport slave (
        input  start_i, rx_i,
        output busy_o, tx_o, sample_o, sample_valid_o, err_o
    );

    modport master (
        output start_i, rx_i,
        input  busy_o, tx_o, sample_o, sample_valid_o, err_o
    );
endinterface

// File: rtl/uart_sample_host.sv
// Host side of the ADC UART readout link: sends the start command byte
// and rebuilds 12-bit samples from the 2-byte frames that come back.
module uart_sample_host #(
    parameter int          CLK_FREQ     = 36_750_000,
    parameter int          BAUD         = 115_200,
    parameter logic [7:0]  START_CMD    = 8'h53,
    parameter logic [3:0]  HDR_NIBBLE   = 4'hA,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart_sample_host_if.slave  bus
);
    localparam int CPB       = CLK_FREQ / BAUD;
    localparam int HALF      = CPB / 2;
    localparam int CNT_W     = $clog2(CPB + 1);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {FR_WAIT_HI, FR_WAIT_LO} fr_state_t;

    // ---------------- transmitter ----------------
    tx_state_t         r_tx_state, w_tx_state_next;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [2:0]        r_tx_bit;
    logic [7:0]        r_tx_shift;
    logic              w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == CNT_W'(CPB - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= START_CMD;
        end else begin
            r_tx_state <= w_tx_state_next;
            if (r_tx_state == TX_IDLE) begin
                r_tx_cnt   <= '0;
                r_tx_bit   <= '0;
                r_tx_shift <= START_CMD;
            end else if (w_tx_bit_end) begin
                r_tx_cnt <= '0;
                if (r_tx_state == TX_DATA) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (bus.start_i) w_tx_state_next = TX_START;
            TX_START: if (w_tx_bit_end) w_tx_state_next = TX_DATA;
            TX_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_state_next = TX_STOP;
            TX_STOP:  if (w_tx_bit_end) w_tx_state_next = TX_IDLE;
            default:  w_tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o = (r_tx_state != TX_IDLE);
        case (r_tx_state)
            TX_START: bus.tx_o = 1'b0;
            TX_DATA:  bus.tx_o = r_tx_shift[0];
            default:  bus.tx_o = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic              r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t         r_rx_state, w_rx_state_next;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [2:0]        r_rx_bit;
    logic [7:0]        r_rx_shift;
    logic              r_rx_break;
    logic              w_rx_fall, w_rx_bit_end, w_rx_half;
    logic              w_rx_start, w_rx_idle, w_byte_valid, w_frame_err;

    assign w_rx_fall    = r_rx_prev & ~r_rx_sync;
    assign w_rx_bit_end = (r_rx_cnt == CNT_W'(CPB - 1));
    assign w_rx_half    = (r_rx_cnt == CNT_W'(HALF - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_break <= 1'b0;
        end else begin
            r_rx_meta  <= bus.rx_i;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_state_next;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt   <= '0;
                    r_rx_bit   <= '0;
                    r_rx_break <= 1'b0;
                end
                RX_START: r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + CNT_W'(1);
                RX_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    // A low stop bit latches r_rx_break until the line idles high again.
                    if (!r_rx_break) begin
                        if (w_rx_bit_end) begin
                            r_rx_cnt   <= '0;
                            r_rx_break <= ~r_rx_sync;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_rx_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_state_next = RX_START;
            RX_START: if (w_rx_half) w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_bit_end && r_rx_bit == 3'd7) w_rx_state_next = RX_STOP;
            RX_STOP: begin
                if (r_rx_break) begin
                    if (r_rx_sync) w_rx_state_next = RX_IDLE;
                end else if (w_rx_bit_end && r_rx_sync) begin
                    w_rx_state_next = RX_IDLE;
                end
            end
            default:  w_rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_idle    = (r_rx_state == RX_IDLE);
        w_rx_start   = w_rx_idle & w_rx_fall;
        w_byte_valid = (r_rx_state == RX_STOP) & ~r_rx_break & w_rx_bit_end & r_rx_sync;
        w_frame_err  = (r_rx_state == RX_STOP) & ~r_rx_break & w_rx_bit_end & ~r_rx_sync;
    end

    // ---------------- frame assembly ----------------
    fr_state_t         r_fr_state, w_fr_state_next;
    logic [3:0]        r_hi;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [11:0]       r_sample;
    logic              r_sample_valid, r_err;
    logic              w_hdr_ok, w_timeout, w_sample_load, w_err_next;

    assign w_hdr_ok = (r_rx_shift[7:4] == HDR_NIBBLE);
    // A start bit detected on the expiry cycle takes precedence over the timeout.
    assign w_timeout = (r_fr_state == FR_WAIT_LO) & w_rx_idle & ~w_rx_start
                     & (r_tmo_cnt == TMO_W'(TMO_LIMIT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fr_state     <= FR_WAIT_HI;
            r_hi           <= '0;
            r_tmo_cnt      <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_fr_state     <= w_fr_state_next;
            r_sample_valid <= w_sample_load;
            r_err          <= w_err_next;
            if (r_fr_state == FR_WAIT_HI && w_byte_valid && w_hdr_ok)
                r_hi <= r_rx_shift[3:0];
            if (w_sample_load)
                r_sample <= {r_hi, r_rx_shift};
            if (r_fr_state == FR_WAIT_HI)
                r_tmo_cnt <= '0;
            else if (w_rx_idle && !w_rx_start)
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    always_comb begin
        w_fr_state_next = r_fr_state;
        case (r_fr_state)
            FR_WAIT_HI: if (w_byte_valid && w_hdr_ok) w_fr_state_next = FR_WAIT_LO;
            FR_WAIT_LO: if (w_byte_valid || w_frame_err || w_timeout) w_fr_state_next = FR_WAIT_HI;
            default:    w_fr_state_next = FR_WAIT_HI;
        endcase
    end

    always_comb begin
        w_sample_load = (r_fr_state == FR_WAIT_LO) & w_byte_valid;
        w_err_next    = w_frame_err | w_timeout
                      | ((r_fr_state == FR_WAIT_HI) & w_byte_valid & ~w_hdr_ok);
    end

    assign bus.sample_o       = r_sample;
    assign bus.sample_valid_o = r_sample_valid;
    assign bus.err_o          = r_err;
endmodule
